vga_tile_capture: RTL and testbench
===================================

Name: vga_tile_capture

Overview:
- Receive-side counterpart of the 640x480 tile-grid VGA generator; consumes hsync/vsync/RGB on the 25 MHz pixel clock.
- Recovers pixel coordinates from the sync edges, checks frame timing and maintains a lock state.
- Samples the centre pixel of each of the 16 tiles in the 4x4 board.
- Publishes the 16 tile colours once per clean frame. Used as a loopback checker and as a board-state readback for the game logic.

Parameters:
- H_TOTAL, 800, pixel clocks per line (hsync rise to hsync rise).
- V_TOTAL, 526, lines per frame (vsync rise to vsync rise).
- X0, 214, x of the left edge of tile column 0.
- Y0, 35, y of the top edge of tile row 0.
- TILE, 117, tile width and height in pixels.
- PITCH, 121, tile-to-tile spacing in pixels (TILE plus a 4-pixel border).

Ports:
- clk  in  1  pixel clock (25 MHz vgaclk domain).
- rst_n  in  1  asynchronous active-low reset.
- hsync  in  1  active-high horizontal sync pulse.
- vsync  in  1  active-high vertical sync pulse.
- r_in, g_in, b_in  in  8 each  pixel colour.
- locked  out  1  timing lock indicator.
- frame_done  out  1  one-cycle pulse when tile_rgb is updated.
- tile_rgb  out  384  tile k = row*4+col occupies bits [24k+23:24k] as {r,g,b}.
- tile_changed  out  16  bit k set when tile k differs from the previous publish.
- err_count  out  8  saturating timing-error counter.
- line_len  out  11  last measured line length.

Behaviour:
- Reset: clk single domain; rst_n is asynchronous active-low. Reset clears all registers: locked=0, frame_done=0, tile_rgb=0, tile_changed=0, err_count=0, line_len=0, state=SEARCH. Reset mid-frame discards the partial frame.
- Input stage: hsync, vsync and rgb are registered once (hs_q, vs_q, rgb_q). hs_q2 and vs_q2 hold the previous samples.
  - hrise = hs_q & ~hs_q2.
  - vrise = vs_q & ~vs_q2.
  - vrise is only acted on in a cycle where hrise is also true.
- Coordinates, both 11-bit:
  - x: the pixel in rgb_q has x=0 in the hrise cycle, then increments each cycle and saturates at 2047.
  - y: 0 for the line starting at vrise, +1 at each other hrise, saturates at 2047.
- Line check: at each hrise, line_len <= (x of previous cycle)+1. A mismatch against H_TOTAL is a line error. The first hrise after leaving SEARCH is not checked.
- Frame check, at vrise: lines = previous y+1. A mismatch against V_TOTAL is a frame error.
- Timeout: x reaching 2047 or y reaching 2047 is a line error (raised once per saturation).
- dirty flag: set by any error, cleared at vrise.
- Sampling: a tile sample is taken when x == X0+col*PITCH+TILE/2 and y == Y0+row*PITCH+TILE/2 (integer divide; defaults 272+121*col, 93+121*row). rgb_q is written into the shadow entry for tile row*4+col. Sampling runs in all states except SEARCH.
- FSM:
  - SEARCH: wait for vrise, then go to ACQUIRE with dirty=0.
  - ACQUIRE, at vrise:
    - Not dirty and lines==V_TOTAL: go to LOCKED and publish.
    - Otherwise stay in ACQUIRE and restart measurement.
  - LOCKED:
    - Any line error: locked drops the next cycle and the state goes to ACQUIRE. The current frame is dirty and is not published.
    - At vrise with a clean frame: publish.
    - At vrise with a frame error: go to ACQUIRE.
- Publish (registered; visible the cycle after vrise):
  - Copy the shadow array into tile_rgb.
  - tile_changed[k] = (new tile k != old tile_rgb tile k).
  - Assert frame_done for exactly one cycle.
  - Set locked=1.
- err_count: +1 in any cycle with one or more errors, so simultaneous line and frame errors count as 1. Saturates at 255 and holds.
- No publish ever happens from SEARCH, and no publish happens for a frame that contained any error.

Test Plan:
- Ideal generator timing (800x526), tile k filled with {r=k*16, g=255-k, b=k}, all else black:
  - locked=0 until the cycle after the 2nd vrise, then locked=1 and frame_done pulses once.
  - tile_rgb tile 5 = {0x50,0xFA,0x05}; tile_changed=16'hFFFF on the first publish and 16'h0000 on the next frame.
- While locked, inject one 801-clock line mid-frame:
  - line_len=801, err_count=1, locked=0 the next cycle.
  - No frame_done at that frame's vrise; relock and frame_done at the following vrise.
- Frame of 525 lines with correct lines: err_count +1 at vrise, no publish, state ACQUIRE; the next clean frame relocks.
- Change only tile 10's colour to {0x12,0x34,0x56} between two clean frames: frame_done pulses, tile_changed=16'h0400, and tile_rgb[263:240]=24'h123456.
- Assert rst_n low mid-frame while locked:
  - All outputs return to 0 immediately (asynchronous).
  - After release, the first frame_done occurs only after two vrise edges.
- Hold hsync low for more than 2048 clocks: err_count increments once at saturation. Running 300 bad lines saturates err_count at 255.

Source files
------------

// File: rtl/vga_tile_capture.sv
// vga_tile_capture
//   Receive side of the 4x4 tile-grid VGA generator. Rebuilds pixel
//   coordinates from hsync/vsync, checks line and frame timing, keeps a lock
//   state and samples the centre pixel of each of the 16 tiles. After every
//   clean frame the 16 colours are published together with a change mask.
//
// Ports
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   hsync, vsync        active-high sync pulses
//   r_in, g_in, b_in    pixel colour
//   locked              timing lock indicator
//   frame_done          one-cycle pulse when tile_rgb is updated
//   tile_rgb            tile k = row*4+col at [24k+23:24k] as {r,g,b}
//   tile_changed        bit k set when tile k differs from the previous publish
//   err_count           saturating timing-error counter
//   line_len            last measured line length
module vga_tile_capture #(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 526,
    parameter int X0      = 214,
    parameter int Y0      = 35,
    parameter int TILE    = 117,
    parameter int PITCH   = 121
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hsync,
    input  logic         vsync,
    input  logic [7:0]   r_in,
    input  logic [7:0]   g_in,
    input  logic [7:0]   b_in,
    output logic         locked,
    output logic         frame_done,
    output logic [383:0] tile_rgb,
    output logic [15:0]  tile_changed,
    output logic [7:0]   err_count,
    output logic [10:0]  line_len
);

    localparam logic [1:0] SEARCH  = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam logic [10:0] H_T   = 11'(H_TOTAL);
    localparam logic [11:0] V_T   = 12'(V_TOTAL);
    localparam logic [10:0] C_MAX = 11'h7FF;

    function automatic logic [10:0] ctr_x(input int col);
        return 11'(X0 + col * PITCH + TILE / 2);
    endfunction

    function automatic logic [10:0] ctr_y(input int row);
        return 11'(Y0 + row * PITCH + TILE / 2);
    endfunction

    logic              hs_q, hs_q2, vs_q, vs_q2;
    logic [23:0]       rgb_q;
    logic [10:0]       x_reg, y_reg;
    logic              x_sat_q, y_sat_q;
    logic              skip;
    logic              dirty;
    logic [1:0]        state;
    logic [15:0][23:0] shadow;

    logic        hrise, vrise, active;
    logic [10:0] cur_x, cur_y;
    logic [11:0] lines;
    logic        len_err, to_err, line_err, frame_err, any_err, publish;

    assign hrise  = hs_q & ~hs_q2;
    // A vsync edge only counts when it lines up with the start of a line.
    assign vrise  = vs_q & ~vs_q2 & hrise;
    assign active = (state != SEARCH);

    // x_reg/y_reg hold the coordinate of the current cycle assuming no sync edge.
    assign cur_x = hrise ? 11'd0 : x_reg;
    assign cur_y = vrise ? 11'd0 :
                   hrise ? ((y_reg == C_MAX) ? y_reg : y_reg + 11'd1) : y_reg;
    assign lines = {1'b0, y_reg} + 12'd1;

    assign len_err   = active & hrise & ~skip & (x_reg != H_T);
    // Saturation is flagged only on the cycle the counter first reaches the top.
    assign to_err    = active & (((cur_x == C_MAX) & ~x_sat_q) |
                                 ((cur_y == C_MAX) & ~y_sat_q));
    assign line_err  = len_err | to_err;
    assign frame_err = active & vrise & (lines != V_T);
    assign any_err   = line_err | frame_err;
    assign publish   = active & vrise & ~dirty & ~line_err & (lines == V_T);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q         <= 1'b0;
            hs_q2        <= 1'b0;
            vs_q         <= 1'b0;
            vs_q2        <= 1'b0;
            rgb_q        <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            x_sat_q      <= 1'b0;
            y_sat_q      <= 1'b0;
            skip         <= 1'b0;
            dirty        <= 1'b0;
            state        <= SEARCH;
            shadow       <= '0;
            locked       <= 1'b0;
            frame_done   <= 1'b0;
            tile_rgb     <= '0;
            tile_changed <= '0;
            err_count    <= '0;
            line_len     <= '0;
        end else begin
            hs_q    <= hsync;
            hs_q2   <= hs_q;
            vs_q    <= vsync;
            vs_q2   <= vs_q;
            rgb_q   <= {r_in, g_in, b_in};
            x_reg   <= (cur_x == C_MAX) ? cur_x : cur_x + 11'd1;
            y_reg   <= cur_y;
            x_sat_q <= (cur_x == C_MAX);
            y_sat_q <= (cur_y == C_MAX);

            if (hrise)
                line_len <= x_reg;

            if (any_err && err_count != 8'hFF)
                err_count <= err_count + 8'd1;

            if (vrise)
                dirty <= 1'b0;
            else if (any_err)
                dirty <= 1'b1;

            // The line that ends at the first hrise after leaving SEARCH is
            // not trusted for the length check.
            if (state == SEARCH && vrise)
                skip <= 1'b1;
            else if (hrise)
                skip <= 1'b0;

            case (state)
                SEARCH:  if (vrise) state <= ACQUIRE;
                ACQUIRE: if (publish) state <= LOCKED;
                LOCKED: begin
                    if (line_err || frame_err) begin
                        state  <= ACQUIRE;
                        locked <= 1'b0;
                    end
                end
                default: state <= SEARCH;
            endcase

            for (int k = 0; k < 16; k++) begin
                if (active && cur_x == ctr_x(k % 4) && cur_y == ctr_y(k / 4))
                    shadow[k] <= rgb_q;
            end

            frame_done <= publish;
            if (publish) begin
                tile_rgb <= shadow;
                locked   <= 1'b1;
                for (int k = 0; k < 16; k++)
                    tile_changed[k] <= (shadow[k] != tile_rgb[24*k +: 24]);
            end
        end
    end

endmodule

// File: tb/tb_vga_tile_capture.sv
// tb_vga_tile_capture
//   Directed bench for vga_tile_capture. A scaled-down raster keeps the run
//   short while preserving the tile-grid geometry. A table of frames carries
//   the expected frame_done count, lock state, error count, peak line length
//   and change mask; hand-written sequences cover asynchronous reset, the
//   sync-loss timeout and error-counter saturation.
module tb_vga_tile_capture;

    localparam int H     = 64;
    localparam int V     = 52;
    localparam int X0    = 4;
    localparam int Y0    = 2;
    localparam int TILE  = 11;
    localparam int PITCH = 13;
    localparam int HS_W  = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         hsync = 1'b0, vsync = 1'b0;
    logic [7:0]   r_in = '0, g_in = '0, b_in = '0;
    logic         locked, frame_done;
    logic [383:0] tile_rgb;
    logic [15:0]  tile_changed;
    logic [7:0]   err_count;
    logic [10:0]  line_len;

    vga_tile_capture #(.H_TOTAL(H), .V_TOTAL(V), .X0(X0), .Y0(Y0),
                       .TILE(TILE), .PITCH(PITCH)) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .locked(locked), .frame_done(frame_done), .tile_rgb(tile_rgb),
        .tile_changed(tile_changed), .err_count(err_count), .line_len(line_len)
    );

    always #20 clk = ~clk;

    typedef struct {
        int          nlines;
        int          bad_line;
        int          bad_len;
        bit          t10;
        int          exp_fd;
        bit          exp_lk;
        int          exp_err;
        int          exp_maxll;
        bit          chk_tc;
        logic [15:0] exp_tc;
    } vec_t;

    vec_t vecs[9];
    int   n_vec = 0, n_fail = 0;
    int   fd_cycles, max_ll;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int hc, input int vc, input bit t10);
        int c, r, k;
        if (hc < X0 || vc < Y0) return 24'h0;
        c = (hc - X0) / PITCH;
        r = (vc - Y0) / PITCH;
        if (c > 3 || r > 3 || (hc - X0) % PITCH >= TILE || (vc - Y0) % PITCH >= TILE)
            return 24'h0;
        k = r * 4 + c;
        if (t10 && k == 10) return 24'h123456;
        return {8'(k * 16), 8'(255 - k), 8'(k)};
    endfunction

    task automatic run_line(input int len, input int vc, input bit t10);
        for (int hc = 0; hc < len; hc++) begin
            @(negedge clk);
            if (frame_done) fd_cycles++;
            if (int'(line_len) > max_ll) max_ll = int'(line_len);
            hsync = (hc < HS_W);
            vsync = (vc < 2);
            {r_in, g_in, b_in} = pix(hc, vc, t10);
        end
    endtask

    task automatic run_frame(input int nl, input int bad, input int blen, input bit t10);
        fd_cycles = 0;
        max_ll = 0;
        for (int vc = 0; vc < nl; vc++)
            run_line((vc == bad) ? blen : H, vc, t10);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hsync = 1'b0;
            vsync = 1'b0;
            {r_in, g_in, b_in} = 24'h0;
        end
    endtask

    initial begin
        //          lines bad  blen t10 fd lk err maxll tc   exp_tc
        vecs[0] = '{V, -1, H,   0, 0, 0, 0, H,   0, 16'h0000};
        vecs[1] = '{V, -1, H,   0, 1, 1, 0, H,   1, 16'hFFFF};
        vecs[2] = '{V, -1, H,   0, 1, 1, 0, H,   1, 16'h0000};
        vecs[3] = '{V, 20, H+1, 0, 1, 0, 1, H+1, 1, 16'h0000};
        vecs[4] = '{V, -1, H,   0, 0, 0, 1, H,   0, 16'h0000};
        vecs[5] = '{V, -1, H,   1, 1, 1, 1, H,   1, 16'h0000};
        vecs[6] = '{V-1, -1, H, 0, 1, 1, 1, H,   1, 16'h0400};
        vecs[7] = '{V, -1, H,   0, 0, 0, 2, H,   0, 16'h0000};
        vecs[8] = '{V, -1, H,   0, 1, 1, 2, H,   1, 16'h0400};

        repeat (3) @(negedge clk);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_err", {24'd0, err_count}, 32'd0);
        check("rst_tiles", {31'd0, tile_rgb == 384'd0}, 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_frame(vecs[i].nlines, vecs[i].bad_line, vecs[i].bad_len, vecs[i].t10);
            check($sformatf("v%0d_fd", i), fd_cycles, vecs[i].exp_fd);
            check($sformatf("v%0d_locked", i), {31'd0, locked}, {31'd0, vecs[i].exp_lk});
            check($sformatf("v%0d_err", i), {24'd0, err_count}, vecs[i].exp_err);
            check($sformatf("v%0d_maxll", i), max_ll, vecs[i].exp_maxll);
            if (vecs[i].chk_tc)
                check($sformatf("v%0d_tc", i), {16'd0, tile_changed}, {16'd0, vecs[i].exp_tc});
            if (i == 1)
                check("tile5", {8'd0, tile_rgb[5*24 +: 24]}, 32'h0050FA05);
            if (i == 6)
                check("tile10", {8'd0, tile_rgb[263:240]}, 32'h00123456);
        end

        // Asynchronous reset in the middle of a locked frame.
        run_frame(20, -1, H, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_locked", {31'd0, locked}, 32'd0);
        check("arst_fd", {31'd0, frame_done}, 32'd0);
        check("arst_tiles", {31'd0, tile_rgb == 384'd0}, 32'd1);
        check("arst_tc", {16'd0, tile_changed}, 32'd0);
        check("arst_err", {24'd0, err_count}, 32'd0);
        check("arst_ll", {21'd0, line_len}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(V, -1, H, 0);
        check("post_rst_fd1", fd_cycles, 0);
        run_frame(V, -1, H, 0);
        check("post_rst_fd2", fd_cycles, 1);
        check("post_rst_locked", {31'd0, locked}, 32'd1);

        // Sync loss: x saturates roughly 2047 cycles after the last hrise.
        idle(1000);
        check("to_before", {24'd0, err_count}, 32'd0);
        idle(1100);
        check("to_once", {24'd0, err_count}, 32'd1);
        check("to_locked", {31'd0, locked}, 32'd0);

        // Every short line is a length error; the counter must stop at 255.
        for (int l = 0; l < 300; l++)
            run_line(20, 600, 0);
        check("err_sat", {24'd0, err_count}, 32'd255);
        check("sat_ll", {21'd0, line_len}, 32'd20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
